wb_write_arbiter: RTL
=====================

# wb_write_arbiter

Shares the regfile's single write port among NUM_REQ writeback sources, such as the ALU result path and the load-return path. Each source gets a one-entry hold buffer with a valid/ready handshake. Held entries are granted round-robin, with same-register ordering preserved, and a registered write (enable/address/data) drives the regfile write port. A pending-register mask is exported for hazard/stall logic.

## Interface
- NUM_REQ, 2, number of writeback requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- req_valid  input  NUM_REQ  requester i offers a write
- req_ready  output  NUM_REQ  requester i may hand over a write this cycle
- req_addr  input  NUM_REQ*ADDR_W  destination register, requester i in slice i
- req_data  input  NUM_REQ*DATA_W  write data, requester i in slice i
- wr_en  output  1  regfile write enable (registered)
- wr_addr  output  ADDR_W  regfile write address (registered)
- wr_data  output  DATA_W  regfile write data (registered)
- pending_mask  output  2^ADDR_W  bit r set while a write to register r is held or on the output stage

## Operation
- Transfer happens on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
- Transfer with req_addr[i]==0 is discarded: no hold is set and the transfer is fully accepted.
- hold_valid[i] set on transfer of a nonzero address. hold_valid[i] clears when granted unless a new transfer refills it at the same edge.
- req_ready[i] = !hold_valid[i] | grant[i]. It is combinational from state and grant only, never from req_valid.
- Age matrix older[i][j] is set when entry i was captured before entry j. For simultaneous capture, the lower index is older.
- Candidate i: held, with no older held entry j whose addr equals addr i.
- Grant is one-hot among candidates, chosen round-robin starting at index rr_ptr. After a grant to k, rr_ptr = (k+1) mod NUM_REQ. With no grant, rr_ptr is held.
- At most one grant per cycle. An output stage loads the granted entry: wr_en=1 with its addr/data. With no grant, wr_en=0 and addr/data are held.
- pending_mask = OR over held entries of decode(addr), OR decode(wr_addr) when wr_en.
- Reset values: hold_valid=0, age matrix=0, rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, pending_mask=0, req_ready=all ones.

## Timing
- Latency: transfer at edge n, granted in cycle n+1, wr_en high in cycle n+2. The regfile commits at the end of n+2, and its read bypass covers cycle n+2.
- Throughput: one write per cycle total. Each uncontested requester can sustain one write per cycle.
- Contention: a held entry waits at most NUM_REQ-1 grant cycles, except when blocked by an older same-address entry. That older entry is itself a candidate, so there is no deadlock.
- Grant and refill at the same edge: the new entry becomes youngest relative to all other held entries.
- Reset asserted mid-operation: all held and output writes are dropped immediately (async), with nothing written. After deassertion, the first grant priority is index 0.

## Structure
- Shared package/define file: ADDR_W, DATA_W defaults, and the zero-register constant. Reuse the existing write-enable/readable macro values.
- One sub-module, rr_pick: a NUM_REQ-wide round-robin one-hot picker taking candidate mask and rr_ptr and returning grant.
- Hold buffers, age matrix, output stage and pending_mask stay in wb_write_arbiter.

## Test plan
- Single write: req 0 sends addr 5 / data 0x1234 at edge 0. Expect wr_en=1, wr_addr=5, wr_data=0x1234 in cycle 2 only; pending_mask[5] high in cycles 1–2.
- Contention: both requesters are valid every cycle with distinct addresses 1..8. Expect grants alternating 0,1,0,1, one wr_en per cycle, and req_ready toggling so that no write is lost.
- Same-address ordering: req 1 sends addr 7 / 0xB at edge 0, req 0 sends addr 7 / 0xA at edge 1, with rr_ptr favouring 0. Expect 0xB written before 0xA.
- x0 drop: req 0 sends addr 0 / 0xFFFF. Expect it accepted (ready stays high), no wr_en ever, and pending_mask stays 0.
- Backpressure: req 0 and req 1 are both valid continuously. Expect req_ready[i] low in the cycle when hold i is full and not granted, and the held data unchanged until granted.
- Reset mid-op: hold both entries and assert rst_in low asynchronously. Expect wr_en, hold and pending_mask at 0 immediately, no write after release, and the first post-reset contended grant goes to requester 0.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter_pkg
// Description : Shared widths and constants for the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_write_arbiter_pkg;

  // Default register address / data widths
  localparam int c_ADDR_W_DEF = 5;
  localparam int c_DATA_W_DEF = 32;

  // Register 0 is hard-wired: writes to it are dropped
  localparam int c_ZERO_REG = 0;

  // Regfile write-enable values
  localparam logic c_WR_ENABLE  = 1'b1;
  localparam logic c_WR_DISABLE = 1'b0;

  // Width of a round-robin pointer over n requesters (at least 1 bit)
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter_rr_pick
// Description : One-hot round-robin picker. Returns the first set candidate
//               at or after rr_ptr, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter_rr_pick
  import wb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_sel_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_rot_pick;

  // Rotate so rr_ptr sits at bit 0, isolate lowest set bit, rotate back
  always_comb begin
    w_dbl      = {cand, cand} >> rr_ptr;
    w_rot      = w_dbl[NUM_REQ-1:0];
    w_rot_pick = w_rot & (~w_rot + NUM_REQ'(1));
    w_sel_dbl  = {w_rot_pick, w_rot_pick} << rr_ptr;
    grant      = w_sel_dbl[2*NUM_REQ-1:NUM_REQ];
  end

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Shares the regfile write port among NUM_REQ writeback
//               sources via one-entry hold buffers, an age matrix for
//               same-register ordering, round-robin grant and a registered
//               write stage. Exports a pending-register mask.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = c_ADDR_W_DEF,
  parameter int DATA_W  = c_DATA_W_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [(1<<ADDR_W)-1:0]    pending_mask
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0]              r_hold_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  r_hold_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]  r_hold_data;
  // r_older[i][j]: entry i was captured before entry j
  logic [NUM_REQ-1:0][NUM_REQ-1:0] r_older;
  logic [PTR_W-1:0]                r_rr_ptr;
  logic                            r_wr_en;
  logic [ADDR_W-1:0]               r_wr_addr;
  logic [DATA_W-1:0]               r_wr_data;

  logic [NUM_REQ-1:0] w_xfer;
  logic [NUM_REQ-1:0] w_cap;
  logic [NUM_REQ-1:0] w_stay;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_grant;
  logic [ADDR_W-1:0]  w_grant_addr;
  logic [DATA_W-1:0]  w_grant_data;
  logic [PTR_W-1:0]   w_next_ptr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_ready[gi] = ~r_hold_valid[gi] | w_grant[gi];
    assign w_xfer[gi]    = req_valid[gi] & req_ready[gi];
    // Writes to the zero register are accepted but never held
    assign w_cap[gi]     = w_xfer[gi] &
                           (req_addr[gi*ADDR_W +: ADDR_W] != ADDR_W'(c_ZERO_REG));
    assign w_stay[gi]    = r_hold_valid[gi] & ~w_grant[gi];
  end

  // An entry is eligible unless an older held entry targets the same register
  always_comb begin
    w_cand = r_hold_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((i != j) && r_hold_valid[j] && r_older[j][i] &&
            (r_hold_addr[j] == r_hold_addr[i])) begin
          w_cand[i] = 1'b0;
        end
      end
    end
  end

  wb_write_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .cand   (w_cand),
    .rr_ptr (r_rr_ptr),
    .grant  (w_grant)
  );

  // Mux the granted entry and compute the pointer that follows it
  always_comb begin
    w_grant_addr = '0;
    w_grant_data = '0;
    w_next_ptr   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_grant_addr = w_grant_addr | r_hold_addr[k];
        w_grant_data = w_grant_data | r_hold_data[k];
        w_next_ptr   = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  // Hold buffers: refill on capture, otherwise drain on grant
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hold_valid <= '0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_cap[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          r_hold_data[i]  <= req_data[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Age matrix: a new capture is younger than every entry that stays held;
  // simultaneous captures order by index
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_older <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (i != j) begin
            if (w_cap[i] && w_cap[j]) begin
              r_older[i][j] <= (i < j);
            end else if (w_cap[i]) begin
              r_older[i][j] <= 1'b0;
            end else if (w_cap[j]) begin
              r_older[i][j] <= w_stay[i];
            end
          end
        end
      end
    end
  end

  // Output stage and round-robin pointer advance on each grant
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_en   <= c_WR_DISABLE;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rr_ptr  <= '0;
    end else if (|w_grant) begin
      r_wr_en   <= c_WR_ENABLE;
      r_wr_addr <= w_grant_addr;
      r_wr_data <= w_grant_data;
      r_rr_ptr  <= w_next_ptr;
    end else begin
      r_wr_en   <= c_WR_DISABLE;
    end
  end

  // Registers with a write still in flight (held or on the output stage)
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_hold_valid[i]) begin
        pending_mask[r_hold_addr[i]] = 1'b1;
      end
    end
    if (r_wr_en) begin
      pending_mask[r_wr_addr] = 1'b1;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule
`default_nettype wire
